// File: rtl/soundbar_meter_pkg.sv
// Shared types and palette constants for the soundbar level meter.
// Each theme lists its colours in slot order: background, border, low, mid, high.
package soundbar_meter_pkg;

  typedef enum logic [2:0] {
    COL_A,
    COL_B,
    COL_C,
    COL_D,
    COL_E
  } col_slot_e;

  localparam int unsigned NumThemes = 4;
  localparam int unsigned NumSlots  = 5;

  localparam logic [15:0] PALETTE [NumThemes][NumSlots] = '{
    '{16'h0841, 16'hFFFF, 16'h07E0, 16'hFFE0, 16'hF800},
    '{16'h0010, 16'hC618, 16'h07FF, 16'h001F, 16'hF81F},
    '{16'h2104, 16'hFD20, 16'h87F0, 16'hFBE0, 16'hF8A0},
    '{16'hFFFF, 16'h0000, 16'h03E0, 16'h7BE0, 16'h7800}
  };

endpackage

// File: rtl/soundbar_palette.sv
// Combinational palette lookup: theme and colour slot to an RGB565 value.
module soundbar_palette
  import soundbar_meter_pkg::*;
(
  input  logic [1:0]  theme_i,
  input  logic [2:0]  slot_i,
  output logic [15:0] colour_o
);

  always_comb begin
    colour_o = '0;
    case (slot_i)
      COL_A:   colour_o = PALETTE[theme_i][0];
      COL_B:   colour_o = PALETTE[theme_i][1];
      COL_C:   colour_o = PALETTE[theme_i][2];
      COL_D:   colour_o = PALETTE[theme_i][3];
      COL_E:   colour_o = PALETTE[theme_i][4];
      default: colour_o = '0;
    endcase
  end

endmodule

// File: rtl/soundbar_meter.sv
// Level meter renderer: frame-synchronous level/peak-hold state and a two-stage
// pixel pipeline that maps a row-major pixel index to an RGB565 colour.
module soundbar_meter
  import soundbar_meter_pkg::*;
#(
  parameter int unsigned WIDTH        = 96,
  parameter int unsigned HEIGHT       = 64,
  parameter int unsigned BORDER       = 3,
  parameter int unsigned LEVEL_W      = 4,
  parameter int unsigned DECAY_FRAMES = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [1:0]         theme,
  input  logic [12:0]        index,
  input  logic               frame_tick,
  input  logic [LEVEL_W-1:0] level,
  input  logic               level_valid,
  input  logic               mute,
  output logic [15:0]        data,
  output logic [LEVEL_W-1:0] level_q,
  output logic [LEVEL_W-1:0] peak_q
);

  localparam int unsigned IdxW   = 13;
  localparam int unsigned InnerH = HEIGHT - 2 * BORDER;
  localparam int unsigned ZoneLo = InnerH / 3;
  localparam int unsigned ZoneHi = (2 * InnerH) / 3;
  localparam int unsigned LMax   = (1 << LEVEL_W) - 1;
  localparam int unsigned NumPix = WIDTH * HEIGHT;
  localparam int unsigned ProdW  = LEVEL_W + IdxW;
  localparam int unsigned HoldW  = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  // Level and peak-hold state, updated only on frame_tick.
  logic [LEVEL_W-1:0] pend_q, pend_d, level_d, peak_d, commit_lvl;
  logic [HoldW-1:0]   hold_q, hold_d;

  always_comb begin
    pend_d     = level_valid ? level : pend_q;
    commit_lvl = mute ? '0 : (level_valid ? level : pend_q);
    level_d    = level_q;
    peak_d     = peak_q;
    hold_d     = hold_q;
    if (frame_tick) begin
      level_d = commit_lvl;
      if (mute) begin
        peak_d = '0;
        hold_d = '0;
      end else if (commit_lvl >= peak_q) begin
        peak_d = commit_lvl;
        hold_d = '0;
      end else if (hold_q == HoldW'(DECAY_FRAMES - 1)) begin
        peak_d = (peak_q != '0) ? peak_q - LEVEL_W'(1) : '0;
        hold_d = '0;
      end else begin
        hold_d = hold_q + HoldW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q  <= '0;
      level_q <= '0;
      peak_q  <= '0;
      hold_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      level_q <= level_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
    end
  end

  // Stage 1: decode index into row and border/out-of-range flags.
  logic [IdxW-1:0] x_d, y_d, y_q;
  logic            border_d, border_q, oob_d, oob_q;
  logic [1:0]      theme_q;

  always_comb begin
    x_d      = index % IdxW'(WIDTH);
    y_d      = index / IdxW'(WIDTH);
    oob_d    = 32'(index) >= NumPix;
    border_d = (32'(x_d) < BORDER) || (32'(x_d) >= WIDTH - BORDER) ||
               (32'(y_d) < BORDER) || (32'(y_d) >= HEIGHT - BORDER);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      y_q      <= '0;
      border_q <= 1'b0;
      oob_q    <= 1'b0;
      theme_q  <= '0;
    end else begin
      y_q      <= y_d;
      border_q <= border_d;
      oob_q    <= oob_d;
      theme_q  <= theme;
    end
  end

  // Stage 2: pick a colour slot and register the palette output.
  logic [IdxW-1:0]  row;
  logic [ProdW-1:0] row_w, lit_rows, peak_rows;
  logic [2:0]       slot;
  logic [15:0]      colour, data_d, data_q;

  always_comb begin
    row       = IdxW'(HEIGHT - 1 - BORDER) - y_q;
    row_w     = ProdW'(row);
    lit_rows  = (ProdW'(level_q) * ProdW'(InnerH)) / ProdW'(LMax);
    peak_rows = (ProdW'(peak_q) * ProdW'(InnerH)) / ProdW'(LMax);
    slot      = COL_A;
    if (border_q) begin
      slot = COL_B;
    end else if ((peak_q > level_q) && (peak_rows != '0) &&
                 (row_w == peak_rows - ProdW'(1))) begin
      slot = COL_E;
    end else if (row_w < lit_rows) begin
      if (row_w < ProdW'(ZoneLo)) begin
        slot = COL_C;
      end else if (row_w < ProdW'(ZoneHi)) begin
        slot = COL_D;
      end else begin
        slot = COL_E;
      end
    end
    data_d = oob_q ? '0 : colour;
  end

  soundbar_palette u_palette (
    .theme_i  (theme_q),
    .slot_i   (slot),
    .colour_o (colour)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: tb/tb_soundbar_meter.sv
// Self-checking bench for soundbar_meter: directed vector table, multi-cycle
// sequences, and a randomized run scored against a behavioural model.
module tb_soundbar_meter;

  localparam int W = 96, H = 64, B = 3, LW = 4, DF = 8;
  localparam int LMAXV = 15, INNER = H - 2 * B;

  localparam logic [15:0] PAL [4][5] = '{
    '{16'h0841, 16'hFFFF, 16'h07E0, 16'hFFE0, 16'hF800},
    '{16'h0010, 16'hC618, 16'h07FF, 16'h001F, 16'hF81F},
    '{16'h2104, 16'hFD20, 16'h87F0, 16'hFBE0, 16'hF8A0},
    '{16'hFFFF, 16'h0000, 16'h03E0, 16'h7BE0, 16'h7800}
  };

  logic        clock = 1'b0, reset_n = 1'b0;
  logic [1:0]  theme = '0;
  logic [12:0] index = '0;
  logic        frame_tick = 1'b0, level_valid = 1'b0, mute = 1'b0;
  logic [3:0]  level = '0;
  logic [15:0] data;
  logic [3:0]  level_q, peak_q;

  int checks = 0, errors = 0;

  soundbar_meter #(
    .WIDTH(W), .HEIGHT(H), .BORDER(B), .LEVEL_W(LW), .DECAY_FRAMES(DF)
  ) dut (
    .clock(clock), .reset_n(reset_n), .theme(theme), .index(index),
    .frame_tick(frame_tick), .level(level), .level_valid(level_valid), .mute(mute),
    .data(data), .level_q(level_q), .peak_q(peak_q)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Colour of one pixel computed directly from the geometric rules.
  function automatic int model_pixel(int th, int idx, int lvl, int pk);
    int x = idx % W;
    int y = idx / W;
    int r, lit, pr;
    if (idx >= W * H) return 0;
    if (x < B || x >= W - B || y < B || y >= H - B) return PAL[th][1];
    r   = H - 1 - B - y;
    lit = lvl * INNER / LMAXV;
    pr  = pk * INNER / LMAXV;
    if (pk > lvl && r == pr - 1) return PAL[th][4];
    if (r < lit) begin
      if (r < INNER / 3) return PAL[th][2];
      if (r < 2 * INNER / 3) return PAL[th][3];
      return PAL[th][4];
    end
    return PAL[th][0];
  endfunction

  // Reference model of level/peak state plus expected-pixel queue.
  int m_pend = 0, m_lvl = 0, m_pk = 0, m_since = 0, m_commit = 0;
  logic [15:0] exp_q[$];

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      m_pend = 0; m_lvl = 0; m_pk = 0; m_since = 0;
      exp_q.delete();
    end else begin
      if (frame_tick) begin
        m_commit = mute ? 0 : (level_valid ? int'(level) : m_pend);
        m_lvl = m_commit;
        if (mute) begin
          m_pk = 0; m_since = 0;
        end else if (m_commit >= m_pk) begin
          m_pk = m_commit; m_since = 0;
        end else begin
          m_since++;
          if (m_since == DF) begin
            m_pk = (m_pk > 0) ? m_pk - 1 : 0;
            m_since = 0;
          end
        end
      end
      if (level_valid) m_pend = int'(level);
      exp_q.push_back(16'(model_pixel(int'(theme), int'(index), m_lvl, m_pk)));
    end
  end

  initial forever begin
    @(negedge clock);
    if (reset_n) begin
      if (exp_q.size() >= 2) check("data_model", data, int'(exp_q.pop_front()));
      check("level_q_model", level_q, m_lvl);
      check("peak_q_model", peak_q, m_pk);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input logic lv, input logic [3:0] lvl, input logic m);
    @(negedge clock);
    level_valid = lv; level = lvl; mute = m; frame_tick = 1'b1;
    @(negedge clock);
    level_valid = 1'b0; mute = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic write_level(input logic [3:0] lvl);
    @(negedge clock);
    level_valid = 1'b1; level = lvl;
    @(negedge clock);
    level_valid = 1'b0;
  endtask

  task automatic pixel(input int idx, input int th, output logic [15:0] d);
    @(negedge clock);
    index = 13'(idx); theme = 2'(th);
    @(negedge clock);
    @(negedge clock);
    d = data;
  endtask

  typedef struct {
    int          lvl;
    int          th;
    int          idx;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] d;
  int          cur;

  initial begin
    vecs.push_back('{0, 0, 0,    PAL[0][1]});
    vecs.push_back('{0, 0, 5,    PAL[0][1]});
    vecs.push_back('{0, 0, 95,   PAL[0][1]});
    vecs.push_back('{0, 0, 6143, PAL[0][1]});
    vecs.push_back('{0, 0, 2928, PAL[0][0]});
    vecs.push_back('{0, 0, 6144, 16'h0000});
    vecs.push_back('{0, 3, 8191, 16'h0000});
    vecs.push_back('{0, 1, 2928, PAL[1][0]});
    vecs.push_back('{1, 0, 5808, PAL[0][2]});
    vecs.push_back('{1, 0, 5712, PAL[0][2]});
    vecs.push_back('{1, 0, 5520, PAL[0][0]});
    vecs.push_back('{1, 2, 5616, PAL[2][2]});
    vecs.push_back('{15, 0, 336,  PAL[0][4]});
    vecs.push_back('{15, 0, 2928, PAL[0][3]});
    vecs.push_back('{15, 0, 4848, PAL[0][2]});
    vecs.push_back('{15, 0, 4080, PAL[0][2]});
    vecs.push_back('{15, 0, 3984, PAL[0][3]});
    vecs.push_back('{15, 0, 2256, PAL[0][3]});
    vecs.push_back('{15, 0, 2160, PAL[0][4]});
    vecs.push_back('{15, 0, 2882, PAL[0][1]});
    vecs.push_back('{15, 0, 2883, PAL[0][3]});
    vecs.push_back('{15, 0, 2972, PAL[0][3]});
    vecs.push_back('{15, 0, 2973, PAL[0][1]});
    vecs.push_back('{15, 0, 5904, PAL[0][1]});
    vecs.push_back('{15, 0, 240,  PAL[0][1]});
    vecs.push_back('{15, 2, 2928, PAL[2][3]});
    vecs.push_back('{15, 3, 4848, PAL[3][2]});
    vecs.push_back('{15, 1, 0,    PAL[1][1]});

    #12;
    check("reset_data", data, 0);
    check("reset_level_q", level_q, 0);
    check("reset_peak_q", peak_q, 0);
    #11 reset_n = 1'b1;

    // Full-frame stream at level 0, scored by the model.
    for (int i = 0; i < W * H; i++) begin
      @(negedge clock);
      index = 13'(i); theme = 2'd0;
    end
    repeat (3) @(negedge clock);

    cur = 0;
    foreach (vecs[i]) begin
      if (vecs[i].lvl != cur) begin
        tick(1'b1, 4'(vecs[i].lvl), 1'b0);
        cur = vecs[i].lvl;
        check("commit_level", level_q, cur);
      end
      pixel(vecs[i].idx, vecs[i].th, d);
      check($sformatf("vec%0d_idx%0d", i, vecs[i].idx), d, vecs[i].exp);
    end

    // Peak hold and decay after the level drops to 0.
    tick(1'b1, 4'd15, 1'b0);
    write_level(4'd0);
    for (int f = 1; f <= 20; f++) begin
      tick(1'b0, 4'd0, 1'b0);
      check($sformatf("decay_peak_f%0d", f), peak_q, 15 - f / 8);
      check($sformatf("decay_level_f%0d", f), level_q, 0);
      if (f == 1) begin
        pixel(336, 0, d);  check("marker_r57", d, PAL[0][4]);
        pixel(5808, 0, d); check("empty_r0", d, PAL[0][0]);
      end
      if (f == 8) begin
        pixel(720, 0, d); check("marker_r53", d, PAL[0][4]);
        pixel(336, 0, d); check("old_marker_r57", d, PAL[0][0]);
      end
    end

    // Bypass, mute and last-write-wins.
    write_level(4'd2);
    repeat (2) @(negedge clock);
    check("no_commit_without_tick", level_q, 0);
    tick(1'b1, 4'd7, 1'b0);
    check("bypass_level", level_q, 7);
    check("bypass_peak_held", peak_q, 13);
    tick(1'b0, 4'd0, 1'b1);
    check("mute_level", level_q, 0);
    check("mute_peak", peak_q, 0);
    tick(1'b0, 4'd0, 1'b0);
    check("unmute_pending", level_q, 7);
    write_level(4'd3);
    write_level(4'd11);
    tick(1'b0, 4'd0, 1'b0);
    check("last_write_wins", level_q, 11);
    tick(1'b0, 4'd0, 1'b1);
    repeat (9) tick(1'b1, 4'd0, 1'b0);
    check("peak_no_wrap", peak_q, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      index       = 13'($urandom_range(0, 8191));
      theme       = 2'($urandom_range(0, 3));
      level       = 4'($urandom_range(0, 15));
      level_valid = ($urandom_range(0, 15) == 0);
      frame_tick  = ($urandom_range(0, 5) == 0);
      mute        = ($urandom_range(0, 39) == 0);
    end
    @(negedge clock);
    level_valid = 1'b0; frame_tick = 1'b0; mute = 1'b0;

    // Asynchronous reset mid-stream.
    tick(1'b1, 4'd9, 1'b0);
    pixel(2928, 0, d);
    check("pre_reset_data", d, PAL[0][3]);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_data", data, 0);
    check("async_reset_level_q", level_q, 0);
    check("async_reset_peak_q", peak_q, 0);
    @(negedge clock);
    #2 reset_n = 1'b1;

    write_level(4'd9);
    repeat (3) @(negedge clock);
    check("post_reset_level_held", level_q, 0);
    pixel(336, 0, d);
    check("post_reset_pixel", d, PAL[0][0]);
    tick(1'b0, 4'd0, 1'b0);
    check("post_reset_commit", level_q, 9);
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/soundbar_meter.md
SOUNDBAR_METER -- requirements
Module: soundbar_meter

Interface
REQ-001 Parameter WIDTH, 96, display width in pixels.
REQ-002 Parameter HEIGHT, 64, display height in pixels.
REQ-003 Parameter BORDER, 3, border thickness in pixels on all four sides.
REQ-004 Parameter LEVEL_W, 4, level width; full scale LMAX = 2^LEVEL_W-1.
REQ-005 Parameter DECAY_FRAMES, 8, frames between peak decrements once the peak is no longer refreshed.
REQ-006 Port clock  in  1  sole clock; all state on its rising edge.
REQ-007 Port reset_n  in  1  reset, asynchronous, active-low.
REQ-008 Port theme  in  2  palette select; 4 themes of 5 colours (A background, B border, C low, D mid, E high).
REQ-009 Port index  in  13  pixel index, row-major: x = index % WIDTH, y = index / WIDTH.
REQ-010 Port frame_tick  in  1  one-cycle pulse at each frame start.
REQ-011 Port level  in  LEVEL_W  requested bar level.
REQ-012 Port level_valid  in  1  captures level into the pending register.
REQ-013 Port mute  in  1  forces the displayed level to 0.
REQ-014 Port data  out  16  RGB565 pixel colour, registered.
REQ-015 Port level_q  out  LEVEL_W  committed level.
REQ-016 Port peak_q  out  LEVEL_W  peak-hold level.

Function
REQ-017 Pending register SHALL load level on any cycle with level_valid=1; last write before a frame_tick wins.
REQ-018 On frame_tick, level_q SHALL commit pending (0 if mute=1); if level_valid and frame_tick coincide, the new level is committed directly (bypass).
REQ-019 Peak update on frame_tick with committed value L: if L>=peak_q then peak_q=L and hold_cnt=0; else if hold_cnt==DECAY_FRAMES-1 then peak_q-=1 and hold_cnt=0; else hold_cnt+=1.
REQ-020 peak_q SHALL never wrap below 0; mute SHALL force peak_q=0 and hold_cnt=0 at the next frame_tick.
REQ-021 Level and peak SHALL change only on frame_tick (no mid-frame tearing).
REQ-022 Pipeline: stage 1 registers x, y and the border flag; stage 2 registers data; latency exactly 2 cycles from index to data, one pixel per cycle, no stalls.
REQ-023 Border: x<BORDER, x>=WIDTH-BORDER, y<BORDER, or y>=HEIGHT-BORDER SHALL give colour B.
REQ-024 Interior: INNER_H = HEIGHT-2*BORDER; row-from-bottom r = HEIGHT-1-BORDER-y.
REQ-025 Lit rows = floor(level_q*INNER_H/LMAX); intermediate product at least LEVEL_W+7 bits, no truncation.
REQ-026 Lit pixel (r < lit rows) colour: C if r < INNER_H/3, D if r < 2*INNER_H/3, else E.
REQ-027 Peak marker: if peak_q>level_q, row r == floor(peak_q*INNER_H/LMAX)-1 SHALL be colour E.
REQ-028 All other interior pixels SHALL be colour A.
REQ-029 index >= WIDTH*HEIGHT SHALL produce data=0.
REQ-030 A theme change SHALL take effect on the pixel whose index arrives in that cycle (palette read in stage 2, theme pipelined with the index).

Reset
REQ-031 reset_n low SHALL asynchronously clear data, level_q, peak_q, pending, hold_cnt and all pipeline registers to 0.
REQ-032 Reset released mid-frame: output is valid 2 cycles after the first post-reset index; level stays 0 until the next frame_tick.

Structure
REQ-033 A shared package SHALL hold the RGB565 palette constants (4 themes x 5 colours) and a colour-slot enum {COL_A..COL_E}.
REQ-034 Sub-module soundbar_palette: combinational theme + slot to 16-bit colour, instantiated once in stage 2.
REQ-035 Zone boundaries and INNER_H SHALL be elaboration-time constants derived from the parameters.

Verification
REQ-036 Reset, theme=0, stream index 0..6143 -> data=B at index 0, 5, 95 and 6143; data=A at y=30, x=48 (level 0).
REQ-037 level=1 with level_valid, then frame_tick; index 5808 (x=48, y=60, r=0) -> 3 lit rows, data=C two cycles later.
REQ-038 level=15 committed -> r=57 (y=3) = E, r=30 (y=30) = D, r=10 = C.
REQ-039 level=15 then level=0 on the following frames -> peak_q=15 for 8 frames, 14 at frame 9, decrementing every 8 frames; marker row r=57 = E while peak_q=15.
REQ-040 level_valid (level=7) coincident with frame_tick -> level_q=7 after that edge; mute=1 at the next frame_tick -> level_q=0, peak_q=0.
REQ-041 reset_n pulsed low mid-stream for 1 cycle -> data, level_q and peak_q are 0 immediately, without waiting for a clock edge.
